riscv_fetch_fifo: RTL and testbench

RISCV_FETCH_FIFO -- requirements
Module: riscv_fetch_fifo

---
 rtl/riscv_fetch_fifo.sv | 144 ++++++++++++++
 tb/tb_riscv_fetch_fifo.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_fetch_fifo.sv
// Instruction prefetch buffer: drives a single-outstanding req/gnt/rvalid memory
// port and queues {address, word} pairs for the decode stage; branches flush it.
module riscv_fetch_fifo #(
    parameter int unsigned DEPTH = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] addr_i,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [31:0] rdata_o,
    output logic [31:0] addr_o,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    output logic        busy_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GNT,
        WAIT_RVALID,
        WAIT_ABORTED
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   fetch_addr_q;
    logic [31:0]   pend_addr_q;
    logic [31:0]   ent_addr_q [DEPTH];
    logic [31:0]   ent_data_q [DEPTH];

    logic [31:0]   branch_addr;
    logic [CW-1:0] eff_cnt;
    logic          room0, room1;
    logic          push, pop, req, decide;
    logic [IW-1:0] wr_idx;

    assign branch_addr  = {addr_i[31:2], 2'b00};
    assign instr_addr_o = branch_i ? branch_addr : fetch_addr_q;
    assign eff_cnt      = branch_i ? '0 : count_q;
    assign room0        = 32'(eff_cnt) < DEPTH;
    // With data landing this cycle, one more slot must stay free for the new request.
    assign room1        = (32'(eff_cnt) + 32'd1) < DEPTH;

    assign valid_o     = (count_q != '0);
    assign rdata_o     = ent_data_q[0];
    assign addr_o      = ent_addr_q[0];
    assign busy_o      = (state_q != IDLE);
    assign instr_req_o = req;

    assign push   = instr_rvalid_i && (state_q == WAIT_RVALID) && !branch_i;
    assign pop    = valid_o && ready_i && !branch_i;
    assign wr_idx = IW'(pop ? count_q - CW'(1) : count_q);
    assign decide = (state_q == IDLE) || (state_q == WAIT_GNT) || instr_rvalid_i;

    always_comb begin
        state_d = state_q;
        req     = 1'b0;
        case (state_q)
            IDLE:         req = req_i && room0;
            WAIT_GNT:     req = 1'b1;
            WAIT_RVALID: begin
                if (instr_rvalid_i) begin
                    req = req_i && (branch_i ? room0 : room1);
                end else if (branch_i) begin
                    state_d = WAIT_ABORTED;
                end
            end
            WAIT_ABORTED: begin
                if (instr_rvalid_i) begin
                    req = req_i && room0;
                end
            end
            default:      req = 1'b0;
        endcase
        if (decide) begin
            if (req) begin
                state_d = instr_gnt_i ? WAIT_RVALID : WAIT_GNT;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (branch_i) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            fetch_addr_q <= '0;
            pend_addr_q  <= '0;
        end else begin
            state_q <= state_d;
            if (req && instr_gnt_i) begin
                fetch_addr_q <= instr_addr_o + 32'd4;
                pend_addr_q  <= instr_addr_o;
            end else if (branch_i) begin
                fetch_addr_q <= branch_addr;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_addr_q[IW'(i)] <= '0;
                ent_data_q[IW'(i)] <= '0;
            end
        end else begin
            count_q <= count_d;
            if (!branch_i) begin
                if (pop) begin
                    for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
                        ent_addr_q[IW'(i)] <= ent_addr_q[IW'(i + 1)];
                        ent_data_q[IW'(i)] <= ent_data_q[IW'(i + 1)];
                    end
                end
                if (push) begin
                    ent_addr_q[wr_idx] <= pend_addr_q;
                    ent_data_q[wr_idx] <= instr_rdata_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_riscv_fetch_fifo.sv
// Randomized and directed bench for riscv_fetch_fifo against a queue-based
// reference model and a single-outstanding memory responder.
module tb_riscv_fetch_fifo;

    localparam int unsigned DEPTH = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i, branch_i, ready_i;
    logic [31:0] addr_i;
    logic        valid_o;
    logic [31:0] rdata_o, addr_o;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i, instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        busy_o;

    always #5 clk = ~clk;

    riscv_fetch_fifo #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_i         (req_i),
        .branch_i      (branch_i),
        .addr_i        (addr_i),
        .ready_i       (ready_i),
        .valid_o       (valid_o),
        .rdata_o       (rdata_o),
        .addr_o        (addr_o),
        .instr_req_o   (instr_req_o),
        .instr_addr_o  (instr_addr_o),
        .instr_gnt_i   (instr_gnt_i),
        .instr_rvalid_i(instr_rvalid_i),
        .instr_rdata_i (instr_rdata_i),
        .busy_o        (busy_o)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: FIFO contents plus the abstract memory-transaction status
    logic [63:0] mq[$];
    bit          m_pend, m_disc, m_wgnt;
    logic [31:0] m_next, m_paddr;

    // Memory responder
    bit          mem_pend;
    int unsigned mem_dly;
    logic [31:0] mem_addr;
    int unsigned lat;
    logic [31:0] glog[$];

    bit          obs_req, obs_valid, obs_busy;
    logic [31:0] obs_iaddr, obs_addr;

    function automatic logic [31:0] hash(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [31:0] glog_at(input int k);
        return (glog.size() > k) ? glog[k] : 32'hDEADBEEF;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_pend = 0; m_disc = 0; m_wgnt = 0;
        m_next = '0; m_paddr = '0;
    endtask

    task automatic do_reset(input bit keep_mem);
        @(negedge clk);
        rst = 1'b1; req_i = 0; branch_i = 0; addr_i = '0; ready_i = 0;
        instr_gnt_i = 0; instr_rvalid_i = 0; instr_rdata_i = '0;
        #1;
        check("rst_valid", valid_o, 0);
        check("rst_req", instr_req_o, 0);
        check("rst_rdata", rdata_o, 0);
        check("rst_addr", addr_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_iaddr", instr_addr_o, 0);
        @(posedge clk);
        model_reset();
        if (!keep_mem) mem_pend = 0;
        glog.delete();
    endtask

    task automatic step(input bit r, input bit b, input logic [31:0] a, input bit rdy, input bit g);
        bit          e_req, rv;
        int unsigned eff;
        logic [31:0] e_iaddr, baddr;
        @(negedge clk);
        rst = 1'b0; req_i = r; branch_i = b; addr_i = a; ready_i = rdy; instr_gnt_i = g;
        rv = mem_pend && (mem_dly == 0);
        instr_rvalid_i = rv;
        instr_rdata_i  = rv ? hash(mem_addr) : $urandom;
        #1;
        baddr = {a[31:2], 2'b00};
        eff   = b ? 0 : mq.size();
        if (m_wgnt)      e_req = 1;
        else if (m_pend) e_req = rv && r && ((m_disc || b) ? (eff < DEPTH) : (eff + 1 < DEPTH));
        else             e_req = r && (eff < DEPTH);
        e_iaddr = b ? baddr : m_next;

        check("instr_req", instr_req_o, e_req);
        check("instr_addr", instr_addr_o, e_iaddr);
        check("busy", busy_o, m_wgnt || m_pend);
        check("valid", valid_o, mq.size() != 0);
        if (mq.size() != 0) begin
            check("head_addr", addr_o, mq[0][63:32]);
            check("head_data", rdata_o, mq[0][31:0]);
        end
        obs_req = instr_req_o; obs_valid = valid_o; obs_busy = busy_o;
        obs_iaddr = instr_addr_o; obs_addr = addr_o;

        @(posedge clk);
        if (!b && mq.size() != 0 && rdy) void'(mq.pop_front());
        if (m_pend && rv) begin
            if (!m_disc && !b) mq.push_back({m_paddr, instr_rdata_i});
            m_pend = 0; m_disc = 0;
        end
        if (b) begin
            mq.delete();
            if (m_pend) m_disc = 1;
        end
        if (e_req && g) begin
            m_pend = 1; m_disc = 0; m_wgnt = 0;
            m_paddr = e_iaddr; m_next = e_iaddr + 32'd4;
        end else begin
            if (e_req) m_wgnt = 1;
            if (b) m_next = baddr;
        end

        if (rv) mem_pend = 0;
        else if (mem_pend) mem_dly--;
        if (e_req && g) begin
            mem_pend = 1; mem_dly = lat; mem_addr = e_iaddr;
            glog.push_back(e_iaddr);
        end
    endtask

    initial begin
        mem_pend = 0; mem_dly = 0; mem_addr = '0; lat = 0;
        model_reset();
        do_reset(0);

        // Branch to 0x100, immediate grant, rvalid with one idle cycle between
        lat = 1;
        step(1, 1, 32'h100, 1, 1);
        check("br100_v0", obs_valid, 0);
        step(1, 0, 0, 1, 1);
        check("br100_v1", obs_valid, 0);
        step(1, 0, 0, 1, 1);
        check("br100_v2", obs_valid, 0);
        step(1, 0, 0, 1, 1);
        check("br100_v3", obs_valid, 1);
        check("br100_addr", obs_addr, 32'h100);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 1);
        check("br100_g0", glog_at(0), 32'h100);
        check("br100_g1", glog_at(1), 32'h104);
        check("br100_g2", glog_at(2), 32'h108);

        // Consumer stalled, zero-wait memory: FIFO fills to DEPTH then stops
        do_reset(0);
        lat = 0;
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 1);
        check("full_req", obs_req, 0);
        check("full_valid", obs_valid, 1);
        check("full_ngnt", glog.size(), DEPTH);
        step(1, 0, 0, 1, 1);
        check("full_pop_req", obs_req, 0);
        step(1, 0, 0, 0, 1);
        check("full_after_pop_req", obs_req, 1);

        // Branch while awaiting rvalid: stale word dropped, new target fetched
        do_reset(0);
        lat = 2;
        step(1, 0, 0, 1, 1);
        step(1, 1, 32'h200, 1, 1);
        check("ab_req", obs_req, 0);
        step(1, 0, 0, 1, 1);
        check("ab_busy", obs_busy, 1);
        step(1, 0, 0, 1, 1);
        check("ab_newreq", obs_req, 1);
        check("ab_newaddr", obs_iaddr, 32'h200);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1);
        check("ab_head", obs_addr, 32'h200);

        // Branch while grant withheld: address swaps, request stays high
        do_reset(0);
        lat = 0;
        step(1, 0, 0, 1, 0);
        check("wg_req0", obs_req, 1);
        step(1, 1, 32'h300, 1, 0);
        check("wg_req1", obs_req, 1);
        check("wg_addr1", obs_iaddr, 32'h300);
        for (int i = 0; i < 2; i++) begin
            step(1, 0, 0, 1, 0);
            check("wg_reqh", obs_req, 1);
            check("wg_addrh", obs_iaddr, 32'h300);
        end
        step(1, 0, 0, 1, 1);
        check("wg_gnt", glog_at(0), 32'h300);

        // Address wrap at the top of memory
        do_reset(0);
        lat = 0;
        step(1, 1, 32'hFFFFFFF8, 1, 1);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 1);
        check("wrap_g0", glog_at(0), 32'hFFFFFFF8);
        check("wrap_g1", glog_at(1), 32'hFFFFFFFC);
        check("wrap_g2", glog_at(2), 32'h00000000);

        // Reset during an outstanding transaction; the late rvalid is ignored
        do_reset(0);
        lat = 2;
        step(1, 0, 0, 1, 1);
        step(0, 0, 0, 1, 0);
        do_reset(1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);
        check("rstmid_valid", obs_valid, 0);
        check("rstmid_busy", obs_busy, 0);
        check("rstmid_mem_done", mem_pend, 0);

        // Randomized traffic
        do_reset(0);
        for (int i = 0; i < 4000; i++) begin
            lat = $urandom_range(0, 2);
            step(($urandom_range(0, 7) != 0), ($urandom_range(0, 15) == 0), $urandom,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
